// File: rtl/lfsr_gen.sv
// Parametrised Galois LFSR with seed load, enable, all-zero lockup recovery
// and on-line measurement of the sequence period.
module lfsr_gen #(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(4'hE),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(4'hF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             lockup,
    output logic             period_done,
    output logic [WIDTH-1:0] period_len,
    output logic [WIDTH-1:0] step_cnt
);

    localparam int unsigned      MSB  = WIDTH - 1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] TAPS = {POLY[MSB:1], 1'b0};

    logic [WIDTH-1:0] start_ref;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] start_ref_d;
    logic [WIDTH-1:0] step_cnt_d;
    logic [WIDTH-1:0] period_len_d;
    logic             lockup_d;
    logic             period_done_d;

    // One Galois step: rotate left, then fold the feedback bit into the tapped stages.
    always_comb begin
        nxt = {q[MSB-1:0], q[MSB]} ^ (TAPS & {WIDTH{q[MSB]}});
    end

    always_comb begin
        q_d           = q;
        start_ref_d   = start_ref;
        step_cnt_d    = step_cnt;
        period_len_d  = period_len;
        lockup_d      = 1'b0;
        period_done_d = 1'b0;
        if (load) begin
            q_d         = seed_in;
            start_ref_d = seed_in;
            step_cnt_d  = '0;
        end else if (en) begin
            if (q == '0) begin
                // All-zero state is a fixed point of the step; escape by reseeding.
                q_d         = SEED;
                start_ref_d = SEED;
                step_cnt_d  = '0;
                lockup_d    = 1'b1;
            end else begin
                q_d = nxt;
                if (nxt == start_ref) begin
                    period_done_d = 1'b1;
                    period_len_d  = step_cnt + ONE;
                    step_cnt_d    = '0;
                end else begin
                    step_cnt_d = step_cnt + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q           <= SEED;
            start_ref   <= SEED;
            step_cnt    <= '0;
            period_len  <= '0;
            lockup      <= 1'b0;
            period_done <= 1'b0;
        end else begin
            q           <= q_d;
            start_ref   <= start_ref_d;
            step_cnt    <= step_cnt_d;
            period_len  <= period_len_d;
            lockup      <= lockup_d;
            period_done <= period_done_d;
        end
    end

    assign serial_out = q[MSB];

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: directed scenarios on the default 4-bit instance, a
// randomized run against a polynomial-arithmetic model, and an 8-bit long run.
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       rst, en, load;
    logic [3:0] seed_in, q, period_len, step_cnt;
    logic       serial_out, lockup, period_done;

    logic       rst8, en8, load8;
    logic [7:0] seed8, q8, len8, cnt8;
    logic       ser8, lock8, done8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lfsr_gen dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
        .q(q), .serial_out(serial_out), .lockup(lockup), .period_done(period_done),
        .period_len(period_len), .step_cnt(step_cnt)
    );

    lfsr_gen #(.WIDTH(8), .POLY(8'h1C), .SEED(8'h01)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .load(load8), .seed_in(seed8),
        .q(q8), .serial_out(ser8), .lockup(lock8), .period_done(done8),
        .period_len(len8), .step_cnt(cnt8)
    );

    // Multiply the state by x modulo the feedback polynomial x^w + taps + 1.
    function automatic int gal(input int s, input int w, input int poly);
        int t;
        t = s << 1;
        if (((t >> w) & 1) == 1) t = t ^ ((1 << w) | (poly & ~1) | 1);
        return t & ((1 << w) - 1);
    endfunction

    // Expected {q, lockup, period_done, period_len, step_cnt} for the 4-bit instance.
    function automatic logic [13:0] pk(input logic [3:0] eq, input logic lk, input logic dn,
                                       input logic [3:0] ln, input logic [3:0] cn);
        return {eq, lk, dn, ln, cn};
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; seed_in = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({q, serial_out, lockup, period_done, period_len, step_cnt} !== {4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset: got q=%h ser=%b lk=%b dn=%b len=%0d cnt=%0d, want q=f ser=1 lk=0 dn=0 len=0 cnt=0",
                     q, serial_out, lockup, period_done, period_len, step_cnt);
        end
    endtask

    task automatic test_sequence();
        logic [13:0] e [8];
        e = '{pk(4'h1,0,0,0,1), pk(4'h2,0,0,0,2), pk(4'h4,0,0,0,3), pk(4'h8,0,0,0,4),
              pk(4'hF,0,1,5,0), pk(4'h1,0,0,5,1), pk(4'h2,0,0,5,2), pk(4'h4,0,0,5,3)};
        rst = 1'b0; en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({q, serial_out, lockup, period_done, period_len, step_cnt} !== {e[k][13:10], e[k][13], e[k][9:0]}) begin
                errors++;
                $display("FAIL sequence step %0d: got q=%h lk=%b dn=%b len=%0d cnt=%0d ser=%b, want %h",
                         k, q, lockup, period_done, period_len, step_cnt, serial_out, e[k]);
            end
        end
    endtask

    task automatic test_hold();
        logic [13:0] e [5];
        logic        ens [5];
        e   = '{pk(4'h4,0,0,5,3), pk(4'h4,0,0,5,3), pk(4'h4,0,0,5,3), pk(4'h8,0,0,5,4), pk(4'hF,0,1,5,0)};
        ens = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 5; k++) begin
            en = ens[k];
            @(posedge clk); #1;
            checks++;
            if ({q, serial_out, lockup, period_done, period_len, step_cnt} !== {e[k][13:10], e[k][13], e[k][9:0]}) begin
                errors++;
                $display("FAIL hold step %0d: got q=%h lk=%b dn=%b len=%0d cnt=%0d, want %h",
                         k, q, lockup, period_done, period_len, step_cnt, e[k]);
            end
        end
    endtask

    task automatic test_load();
        logic [13:0] e [6];
        e = '{pk(4'h2,0,0,5,0), pk(4'h4,0,0,5,1), pk(4'h8,0,0,5,2), pk(4'hF,0,0,5,3),
              pk(4'h1,0,0,5,4), pk(4'h2,0,1,5,0)};
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            load = (k == 0); seed_in = (k == 0) ? 4'h2 : 4'(($urandom % 15) + 1);
            @(posedge clk); #1;
            checks++;
            if ({q, serial_out, lockup, period_done, period_len, step_cnt} !== {e[k][13:10], e[k][13], e[k][9:0]}) begin
                errors++;
                $display("FAIL load step %0d: got q=%h lk=%b dn=%b len=%0d cnt=%0d, want %h",
                         k, q, lockup, period_done, period_len, step_cnt, e[k]);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_zero_lockup();
        logic [13:0] e [3];
        e = '{pk(4'h0,0,0,5,0), pk(4'hF,1,0,5,0), pk(4'h1,0,0,5,1)};
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            load = (k == 0); seed_in = 4'h0;
            @(posedge clk); #1;
            checks++;
            if ({q, serial_out, lockup, period_done, period_len, step_cnt} !== {e[k][13:10], e[k][13], e[k][9:0]}) begin
                errors++;
                $display("FAIL zero_lockup step %0d: got q=%h lk=%b dn=%b len=%0d cnt=%0d, want %h",
                         k, q, lockup, period_done, period_len, step_cnt, e[k]);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_reset_override();
        logic [13:0] e [4];
        e = '{pk(4'h2,0,0,5,2), pk(4'h4,0,0,5,3), pk(4'h8,0,0,5,4), pk(4'hF,0,0,0,0)};
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rst = (k == 3); load = (k == 3); seed_in = 4'h6;
            @(posedge clk); #1;
            checks++;
            if ({q, serial_out, lockup, period_done, period_len, step_cnt} !== {e[k][13:10], e[k][13], e[k][9:0]}) begin
                errors++;
                $display("FAIL reset_override step %0d: got q=%h lk=%b dn=%b len=%0d cnt=%0d, want %h",
                         k, q, lockup, period_done, period_len, step_cnt, e[k]);
            end
        end
        rst = 1'b0; load = 1'b0;
    endtask

    task automatic test_random();
        int m_q, m_ref, m_cnt, m_len, n;
        bit m_lk, m_dn;
        bit r, l, e;
        logic [3:0] s;
        rst = 1'b1; load = 1'b0; en = 1'b0;
        @(posedge clk); #1;
        m_q = 15; m_ref = 15; m_cnt = 0; m_len = 0; m_lk = 0; m_dn = 0;
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 49) == 0);
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            s = 4'($urandom);
            rst = r; load = l; en = e; seed_in = s;
            m_lk = 0; m_dn = 0;
            if (r) begin
                m_q = 15; m_ref = 15; m_cnt = 0; m_len = 0;
            end else if (l) begin
                m_q = int'(s); m_ref = int'(s); m_cnt = 0;
            end else if (e) begin
                if (m_q == 0) begin
                    m_q = 15; m_ref = 15; m_cnt = 0; m_lk = 1;
                end else begin
                    n = gal(m_q, 4, 'hE);
                    m_q = n;
                    if (n == m_ref) begin
                        m_dn = 1; m_len = m_cnt + 1; m_cnt = 0;
                    end else begin
                        m_cnt++;
                    end
                end
            end
            @(posedge clk); #1;
            checks++;
            if ({q, serial_out, lockup, period_done, period_len, step_cnt} !==
                {4'(m_q), m_q[3], m_lk, m_dn, 4'(m_len), 4'(m_cnt)}) begin
                errors++;
                $display("FAIL random cycle %0d: got q=%h ser=%b lk=%b dn=%b len=%0d cnt=%0d, want q=%h lk=%b dn=%b len=%0d cnt=%0d",
                         k, q, serial_out, lockup, period_done, period_len, step_cnt, m_q, m_lk, m_dn, m_len, m_cnt);
            end
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_wide();
        int m8, since, dones;
        rst8 = 1'b1; en8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({q8, len8, cnt8, lock8, done8} !== {8'h01, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL wide_reset: got q=%h len=%0d cnt=%0d lk=%b dn=%b", q8, len8, cnt8, lock8, done8);
        end
        rst8 = 1'b0; en8 = 1'b1;
        m8 = 1; since = 0; dones = 0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            m8 = gal(m8, 8, 'h1C);
            since++;
            checks++;
            if (q8 !== 8'(m8) || q8 === 8'h00 || lock8 !== 1'b0 || done8 !== (m8 == 1) || ser8 !== q8[7]) begin
                errors++;
                $display("FAIL wide cycle %0d: got q=%h lk=%b dn=%b ser=%b, want q=%h lk=0 dn=%b",
                         k, q8, lock8, done8, ser8, m8, (m8 == 1));
            end
            if (m8 == 1) begin
                dones++;
                checks++;
                if (since != 255 || len8 !== 8'd255 || cnt8 !== 8'd0) begin
                    errors++;
                    $display("FAIL wide_period: got len=%0d cnt=%0d spacing=%0d, want 255 0 255", len8, cnt8, since);
                end
                since = 0;
            end
        end
        checks++;
        if (dones != 2) begin
            errors++;
            $display("FAIL wide_done_count: got %0d, want 2", dones);
        end
        en8 = 1'b0;
    endtask

    initial begin
        rst8 = 1'b1; en8 = 1'b0; load8 = 1'b0; seed8 = 8'h00;
        test_reset();
        test_sequence();
        test_hold();
        test_load();
        test_zero_lockup();
        test_reset_override();
        test_random();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised Galois LFSR sequence generator with synchronous seed load, enable, all-zero lockup recovery and on-line period measurement.
- Generalises the fixed 4-bit preset-to-ones LFSR register to any WIDTH, polynomial and seed.
- Used as the pseudo-random source and self-test pattern generator in the AC lab designs.

Parameters:
- WIDTH, 4, state width in bits (>=2).
- POLY, 4'hE, Galois tap mask: bit i (i>=1) set means q[W-1] is XORed into stage i; bit 0 is ignored (stage 0 is always fed by q[W-1]).
- SEED, 4'hF, state loaded on reset and on lockup recovery; must be non-zero.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  advance the LFSR by one step this cycle
- load  input  1  load seed_in this cycle
- seed_in  input  WIDTH  value taken by load
- q  output  WIDTH  current LFSR state
- serial_out  output  1  q[WIDTH-1]
- lockup  output  1  one-cycle pulse: all-zero state was detected and SEED reloaded
- period_done  output  1  one-cycle pulse: state has just returned to the start reference
- period_len  output  WIDTH  length of the last completed period, in steps
- step_cnt  output  WIDTH  steps taken since the start reference was set

Behaviour:
- Reset values: q=SEED; start reference=SEED; step_cnt=0; period_len=0; lockup=0; period_done=0.
- All registers update on the rising edge of clk only. Priority is rst > load > en > hold.
- Step function: nxt[0]=q[W-1]; for i>=1, nxt[i]=q[i-1]^(POLY[i]&q[W-1]).
- With the defaults, the sequence from F is F,1,2,4,8,F, so the period is 5.
- load=1:
  - q<=seed_in; start reference<=seed_in; step_cnt<=0.
  - period_len is held; no pulses are generated.
  - en is ignored that cycle.
  - seed_in=0 is accepted.
- en=1 (no load), q!=0:
  - q<=nxt.
  - If nxt==start reference: period_done=1 next cycle, period_len<=step_cnt+1, step_cnt<=0.
  - Otherwise step_cnt<=step_cnt+1.
- en=1 (no load), q==0: this is the lockup case.
  - q<=SEED; start reference<=SEED; step_cnt<=0; lockup=1 next cycle.
  - No period_done is generated.
- en=0 and load=0: everything holds. lockup and period_done return to 0, because they are registered pulses lasting exactly one cycle.
- step_cnt width: WIDTH bits is sufficient, since the maximum period is 2^WIDTH-1. It never wraps under a valid (non-zero) start reference.
- rst asserted mid-sequence overrides load and en. The next cycle shows the reset values.
- Pulse timing: lockup and period_done are asserted in the same cycle that q shows the new state.

Test Plan:
- Default params; rst high for 2 cycles, then low with en=1 continuously -> q sequence F,1,2,4,8,F,1,...; period_done high exactly when q returns to F; period_len=5 from then on; step_cnt cycles 0..4.
- Hold en=0 for 3 cycles mid-sequence at q=4 -> q, step_cnt and period_len are unchanged and no pulses occur; resume -> 8,F with period_done.
- load=1 with seed_in=2 while en=1 -> q=2 next cycle, step_cnt=0; sequence 4,8,F,1,2 with period_done on the return to 2; period_len=5.
- load seed_in=0, then en=1 -> q stays 0 for the load cycle; next step gives q=F with lockup=1 for one cycle and no period_done; normal sequence follows.
- Assert rst at q=8 together with load=1 and en=1 -> next cycle q=F, step_cnt=0, period_len=0, both pulses 0.
- WIDTH=8, POLY=8'h1C, SEED=8'h01; en=1 for 600 cycles -> period_done every 255 steps, period_len=255, q never 0, lockup never asserted.
